// File: rtl/parity_frame_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : parity_frame_receiver
// Purpose  : Asynchronous serial receiver for 5-bit parity codewords
//            (4 data bits + parity bit in the LSB). The line carries a start
//            bit, codeword bit4..bit0 MSB first, and a stop bit. Each frame
//            is checked for even/odd parity and a valid stop bit. A
//            saturating counter tracks how many frames were in error.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            rx         - serial line, idle high, asynchronous to clk
//            odd_mode   - 1 = odd parity expected, 0 = even (latched at start)
//            clr_err    - synchronous clear of err_count (wins over increment)
//            data_out   - received data bits, codeword[4:1]
//            codeword   - received codeword, bit0 = parity bit
//            data_valid - one-cycle pulse when a frame completes
//            parity_err - parity mismatch, qualified by data_valid
//            frame_err  - stop bit sampled low, qualified by data_valid
//            busy       - high whenever the receiver is not idle
//            err_count  - saturating count of erroneous frames
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 odd_mode,
  input  logic                 clr_err,
  output logic [3:0]           data_out,
  output logic [4:0]           codeword,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  // Start bit is checked mid-bit; every later bit is sampled one full bit
  // period after the previous sample, so all samples stay mid-bit.
  localparam logic [CNT_W-1:0] START_SAMPLE = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_SAMPLE   = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync_meta;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [4:0]       shift_reg;
  logic             odd_latched;
  logic             armed;
  logic             sample;
  logic             frame_done;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      sync_meta <= rx;
      rxs       <= sync_meta;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and sample-strobe logic
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs && armed) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt == START_SAMPLE) begin
          sample     = 1'b1;
          // A line that is high again at mid-start-bit was only a glitch.
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_SAMPLE) begin
          sample = 1'b1;
          if (bit_idx == 3'd0) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == BIT_SAMPLE) begin
          sample     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign frame_done = (state == STOP) && sample;
  assign busy       = (state != IDLE);

  // Bit timing, shift register and frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift_reg   <= 5'd0;
      odd_latched <= 1'b0;
      armed       <= 1'b1;
    end else begin
      if (sample || (state_next != state)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if ((state == START) && (state_next == DATA)) begin
        bit_idx <= 3'd4;
      end else if ((state == DATA) && sample) begin
        bit_idx <= bit_idx - 3'd1;
      end

      if ((state == DATA) && sample) begin
        shift_reg <= {shift_reg[3:0], rxs};
      end

      if ((state == IDLE) && (state_next == START)) begin
        odd_latched <= odd_mode;
      end

      // A frame ending on a low stop bit disarms start detection until the
      // line has been seen high again, so a held-low break reports once.
      if (frame_done && !rxs) begin
        armed <= 1'b0;
      end else if ((state == IDLE) && rxs) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      codeword   <= 5'd0;
      data_out   <= 4'd0;
    end else begin
      data_valid <= frame_done;
      parity_err <= frame_done & ((^shift_reg) ^ odd_latched);
      frame_err  <= frame_done & ~rxs;
      if (frame_done) begin
        codeword <= shift_reg;
        data_out <= shift_reg[4:1];
      end
    end
  end

  // Saturating error counter; clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (data_valid && (parity_err || frame_err) && !(&err_count)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_receiver
// Purpose  : Directed self-checking bench for parity_frame_receiver with
//            CLKS_PER_BIT = 4 and a 2-bit error counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_receiver;

  localparam int C  = 4;
  localparam int EW = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          rx       = 1'b1;
  logic          odd_mode = 1'b0;
  logic          clr_err  = 1'b0;
  logic [3:0]    data_out;
  logic [4:0]    codeword;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
  logic [EW-1:0] err_count;

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int dv_count = 0;
  int fall_cyc = 0;
  int dv0      = 0;

  logic [4:0] cw_h    [0:31];
  logic [3:0] do_h    [0:31];
  logic       pe_h    [0:31];
  logic       fe_h    [0:31];
  logic       busy_h  [0:31];
  int         dvcyc_h [0:31];

  parity_frame_receiver #(
    .CLKS_PER_BIT(C),
    .ERR_CNT_W   (EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .odd_mode  (odd_mode),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .codeword  (codeword),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every data_valid pulse together with the outputs it qualifies.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (dv_count < 32) begin
        cw_h[dv_count]    = codeword;
        do_h[dv_count]    = data_out;
        pe_h[dv_count]    = parity_err;
        fe_h[dv_count]    = frame_err;
        busy_h[dv_count]  = busy;
        dvcyc_h[dv_count] = cyc;
      end
      dv_count = dv_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(C);
  endtask

  // Start, codeword MSB first, stop. The line is left at the stop level.
  task automatic send_frame(input logic [4:0] cw, input logic stop_bit);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 4; i >= 0; i--) send_bit(cw[i]);
    send_bit(stop_bit);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_dv",   data_valid, 0);
    check("rst_busy", busy,       0);
    check("rst_cw",   codeword,   0);
    check("rst_do",   data_out,   0);
    check("rst_pe",   parity_err, 0);
    check("rst_fe",   frame_err,  0);
    check("rst_ec",   err_count,  0);
    rst_n = 1'b1;
    tick(5);

    // Even mode, codeword 10111 has four ones: clean frame
    odd_mode = 1'b0;
    dv0 = dv_count;
    send_frame(5'b10111, 1'b1);
    tick(4);
    check("t1_dvcnt",   dv_count, dv0 + 1);
    check("t1_cw",      cw_h[dv0], 5'b10111);
    check("t1_do",      do_h[dv0], 4'b1011);
    check("t1_pe",      pe_h[dv0], 0);
    check("t1_fe",      fe_h[dv0], 0);
    check("t1_busy_dv", busy_h[dv0], 0);
    // rx driven after edge P; first synchronizer edge is P+1, and
    // data_valid is seen 28 edges later, in the cycle after edge P+29.
    check("t1_latency", dvcyc_h[dv0] - fall_cyc, 29);
    check("t1_ec",      err_count, 0);

    // Odd mode: 10111 is a parity error, 10110 (three ones) is clean
    odd_mode = 1'b1;
    dv0 = dv_count;
    send_frame(5'b10111, 1'b1);
    tick(4);
    check("t2a_dvcnt", dv_count, dv0 + 1);
    check("t2a_pe",    pe_h[dv0], 1);
    check("t2a_fe",    fe_h[dv0], 0);
    check("t2a_ec",    err_count, 1);
    dv0 = dv_count;
    send_frame(5'b10110, 1'b1);
    tick(4);
    check("t2b_dvcnt", dv_count, dv0 + 1);
    check("t2b_pe",    pe_h[dv0], 0);
    check("t2b_cw",    cw_h[dv0], 5'b10110);
    check("t2b_ec",    err_count, 1);

    // Low stop bit, then the line stays low for three more frame times
    dv0 = dv_count;
    send_frame(5'b10110, 1'b0);
    tick(4);
    check("t3_dvcnt", dv_count, dv0 + 1);
    check("t3_fe",    fe_h[dv0], 1);
    check("t3_pe",    pe_h[dv0], 0);
    check("t3_ec",    err_count, 2);
    tick(3 * 7 * C);
    check("t3_brk_dv",   dv_count, dv0 + 1);
    check("t3_brk_busy", busy, 0);
    rx = 1'b1;
    tick(12);
    check("t3_rel_dv", dv_count, dv0 + 1);

    // One-cycle glitch: detected as a start, rejected at the start sample
    odd_mode = 1'b0;
    dv0 = dv_count;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(2);
    check("t4_busy_hi", busy, 1);
    tick(10);
    check("t4_busy_lo", busy, 0);
    check("t4_dvcnt",   dv_count, dv0);

    // Back-to-back frames, even mode
    dv0 = dv_count;
    send_frame(5'b00000, 1'b1);
    send_frame(5'b11110, 1'b1);
    tick(4);
    check("t5_dvcnt", dv_count, dv0 + 2);
    check("t5_cw0",   cw_h[dv0], 5'b00000);
    check("t5_cw1",   cw_h[dv0 + 1], 5'b11110);
    check("t5_do1",   do_h[dv0 + 1], 4'b1111);
    check("t5_pe0",   pe_h[dv0], 0);
    check("t5_pe1",   pe_h[dv0 + 1], 0);
    check("t5_ec",    err_count, 2);

    // Clear, then saturate a 2-bit counter with parity-errored frames
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t6_clr", err_count, 0);
    for (int i = 0; i < 5; i++) begin
      send_frame(5'b11001, 1'b1);
      tick(4);
      if (i == 2) check("t6_ec3", err_count, 3);
    end
    check("t6_sat", err_count, 3);
    // Sixth errored frame with clr_err in its data_valid cycle
    send_frame(5'b11001, 1'b1);
    tick(1);
    check("t6_dv_now", data_valid, 1);
    check("t6_pe_now", parity_err, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t6_clr_win", err_count, 0);
    tick(2);
    send_frame(5'b11001, 1'b1);
    tick(4);
    check("t6_ec1", err_count, 1);
    check("t6_do",  data_out, 4'b1100);

    // Reset during DATA bit 2
    dv0 = dv_count;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    tick(2);
    check("t7_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t7_do",   data_out,   0);
    check("t7_cw",   codeword,   0);
    check("t7_ec",   err_count,  0);
    check("t7_busy", busy,       0);
    check("t7_dv",   data_valid, 0);
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("t7_no_dv", dv_count, dv0);
    send_frame(5'b01100, 1'b1);
    tick(4);
    check("t7_dvcnt", dv_count, dv0 + 1);
    check("t7_cw2",   cw_h[dv0], 5'b01100);
    check("t7_do2",   do_h[dv0], 4'b0110);
    check("t7_pe2",   pe_h[dv0], 0);
    check("t7_fe2",   fe_h[dv0], 0);
    check("t7_ec2",   err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
